// File: rtl/sram_fill_writer_pkg.sv
// Shared constants for the instruction SRAM: geometry, bank/row split and
// the fill-writer state encoding used by the writer, array and fetch side.
package sram_fill_writer_pkg;

   localparam int DATA_W     = 72;
   localparam int ADDR_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int SRAM_BANKS = 8;
   localparam int BANK_W     = 3;
   localparam int ROW_W      = ADDR_W - BANK_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
      return addr[BANK_W-1:0];
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:BANK_W];
   endfunction

endpackage

// File: rtl/sram_fill_writer_sync_fifo.sv
// Single-clock FIFO with combinational head; push while full is legal
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 4
) (
   input  logic             i_fire,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_head  = mem_q[rd_ptr_q];

   assign push_ok = i_push && (!o_full || i_pop);
   assign pop_ok  = i_pop && !o_empty;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared too so the head reads as zero straight out of reset.
   always_ff @(posedge i_fire) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sram_fill_writer.sv
// Write-side sequencer for the instruction SRAM: buffers a word stream and
// writes it at consecutive addresses, yielding whenever the fetch side reads.
//
//  state | meaning
//  IDLE  | waiting for i_start
//  FILL  | accepting words and writing them out
//  DONE  | one-cycle completion pulse
module sram_fill_writer
   import sram_fill_writer_pkg::*;
(
   input  logic              i_fire,
   input  logic              rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_baseAddr,
   input  logic [ADDR_W:0]   i_len,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   input  logic              i_readReq,
   output logic              o_write_en,
   output logic [ADDR_W-1:0] o_writeAddr,
   output logic [DATA_W-1:0] o_writeData,
   output logic              o_busy,
   output logic              o_done
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   acc_left_q, acc_left_d;
   logic [ADDR_W:0]   wr_left_q, wr_left_d;

   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              push, pop;

   assign o_ready     = (state_q == ST_FILL) && !fifo_full && (acc_left_q != '0);
   assign push        = i_valid && o_ready;
   assign o_write_en  = (state_q == ST_FILL) && !fifo_empty && !i_readReq;
   assign pop         = o_write_en;
   assign o_writeAddr = wr_addr_q;
   assign o_writeData = fifo_head;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_DONE);

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_fire      (i_fire),
      .rst         (rst),
      .i_push      (push),
      .i_push_data (i_data),
      .i_pop       (pop),
      .o_head      (fifo_head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      acc_left_d = acc_left_q;
      wr_left_d  = wr_left_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               wr_addr_d  = i_baseAddr;
               acc_left_d = i_len;
               wr_left_d  = i_len;
               state_d    = (i_len == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (push) acc_left_d = acc_left_q - (ADDR_W+1)'(1);
            if (pop) begin
               wr_addr_d = wr_addr_q + ADDR_W'(1);
               wr_left_d = wr_left_q - (ADDR_W+1)'(1);
               if (wr_left_q == (ADDR_W+1)'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_fire) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_addr_q  <= '0;
         acc_left_q <= '0;
         wr_left_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         acc_left_q <= acc_left_d;
         wr_left_q  <= wr_left_d;
      end
   end

endmodule

// File: tb/tb_sram_fill_writer.sv
// Directed + randomized bench for sram_fill_writer; a scoreboard of
// expected (address, data) writes is filled on accept and drained on write.
module tb_sram_fill_writer;
   import sram_fill_writer_pkg::*;

   logic              i_fire = 1'b0;
   logic              rst = 1'b0;
   logic              i_start = 1'b0;
   logic [ADDR_W-1:0] i_baseAddr = '0;
   logic [ADDR_W:0]   i_len = '0;
   logic              i_valid = 1'b0;
   logic [DATA_W-1:0] i_data = '0;
   logic              o_ready;
   logic              i_readReq = 1'b0;
   logic              o_write_en;
   logic [ADDR_W-1:0] o_writeAddr;
   logic [DATA_W-1:0] o_writeData;
   logic              o_busy;
   logic              o_done;

   sram_fill_writer dut (
      .i_fire      (i_fire),
      .rst         (rst),
      .i_start     (i_start),
      .i_baseAddr  (i_baseAddr),
      .i_len       (i_len),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .o_ready     (o_ready),
      .i_readReq   (i_readReq),
      .o_write_en  (o_write_en),
      .o_writeAddr (o_writeAddr),
      .o_writeData (o_writeData),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_fire = ~i_fire;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t sb[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  wr_cnt = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  wr_cyc[4096];
   int  wcount[256];
   int  snap[256];
   int  first_acc;
   int  fill_wr0;
   bit  ready_drop;

   always @(posedge i_fire) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write-port monitor: every write must match the oldest accepted word.
   always @(negedge i_fire) begin
      wr_t e;
      if (o_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (o_write_en === 1'b1) begin
         chk("write_during_read", 96'(i_readReq), 96'(0));
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_write observed addr=%0h data=%0h expected none", o_writeAddr, o_writeData);
         end else begin
            e = sb.pop_front();
            chk("write_addr", 96'(o_writeAddr), 96'(e.addr));
            chk("write_data", 96'(o_writeData), 96'(e.data));
         end
         wr_cyc[wr_cnt] = cyc;
         wr_cnt++;
         wcount[o_writeAddr]++;
      end
   end

   task automatic run_fill(input logic [ADDR_W-1:0] base, input int len, input int vpct,
                           input int rpct, input bit rr_win, input bit extra,
                           input bit restart, input bit seq);
      int idx = 0;
      int k = 0;
      bit fin = 0;
      bit past;
      int dn0 = done_cnt;
      logic [DATA_W-1:0] d;
      fill_wr0   = wr_cnt;
      first_acc  = -1;
      ready_drop = 0;
      @(posedge i_fire); #1;
      i_start = 1'b1; i_baseAddr = base; i_len = (ADDR_W+1)'(len);
      @(posedge i_fire); #1;
      i_start = 1'b0;
      while (!fin && k < 2000) begin
         d = seq ? DATA_W'(idx) : {$urandom(), $urandom(), 8'(idx)};
         i_data    = d;
         i_valid   = ((idx < len) || extra) && ($urandom_range(99) < vpct);
         i_readReq = rr_win ? (k >= 3 && k <= 6) : ($urandom_range(99) < rpct);
         if (restart && k == 1) begin
            i_start = 1'b1; i_baseAddr = ~base; i_len = 9'd5;
         end else begin
            i_start = 1'b0;
         end
         @(negedge i_fire);
         past = (idx >= len);
         if (extra && past && i_valid) chk("ready_after_len", 96'(o_ready), 96'(0));
         if (i_valid && o_ready) begin
            if (past) begin
               tests++;
               fails++;
               $error("FAIL over_accept observed idx=%0d expected at most %0d", idx, len);
            end
            sb.push_back('{addr: base + ADDR_W'(idx), data: d});
            if (first_acc < 0) first_acc = cyc;
            idx++;
         end else if (i_valid && !past) begin
            ready_drop = 1;
         end
         if (o_done) fin = 1;
         @(posedge i_fire); #1;
         k++;
      end
      i_valid = 1'b0; i_readReq = 1'b0; i_start = 1'b0;
      chk("fill_completed", 96'(fin), 96'(1));
      chk("words_accepted", 96'(idx), 96'(len));
      chk("words_written", 96'(wr_cnt - fill_wr0), 96'(len));
      chk("done_pulses", 96'(done_cnt - dn0), 96'(1));
      chk("scoreboard_empty", 96'(sb.size()), 96'(0));
      @(negedge i_fire);
      chk("idle_after_done", 96'({o_busy, o_done, o_write_en}), 96'(0));
   endtask

   initial begin
      int dn0;
      int wr0;
      int idx;
      int bad;
      logic [ADDR_W-1:0] b;

      // Reset held with start/valid asserted: everything stays quiet.
      i_start = 1'b1; i_valid = 1'b1; i_len = 9'd5; i_baseAddr = 8'h33;
      repeat (2) begin
         @(negedge i_fire);
         chk("reset_outputs", 96'({o_ready, o_write_en, o_busy, o_done, o_writeAddr, o_writeData}), 96'(0));
      end
      @(posedge i_fire); #1;
      rst = 1'b1; i_start = 1'b0; i_valid = 1'b0;
      @(negedge i_fire);
      chk("idle_after_reset", 96'({o_busy, o_ready, o_write_en}), 96'(0));

      // Back-to-back fill, checking latency and consecutive writes.
      run_fill(8'h10, 8, 100, 0, 0, 0, 0, 1);
      chk("first_write_latency", 96'(wr_cyc[fill_wr0] - first_acc), 96'(1));
      chk("consecutive_writes", 96'(wr_cyc[fill_wr0 + 7] - wr_cyc[fill_wr0]), 96'(7));
      chk("done_after_last", 96'(done_cyc - wr_cyc[fill_wr0 + 7]), 96'(1));

      // Read requests in cycles 3-6 stall writes and back-pressure the stream.
      run_fill(8'h10, 8, 100, 0, 1, 0, 0, 1);
      chk("ready_dropped_when_full", 96'(ready_drop), 96'(1));

      // Address wrap.
      run_fill(8'hFE, 4, 100, 0, 0, 0, 0, 0);

      // Zero-length fill.
      dn0 = done_cnt; wr0 = wr_cnt;
      @(posedge i_fire); #1;
      i_start = 1'b1; i_baseAddr = 8'h33; i_len = 9'd0;
      @(posedge i_fire); #1;
      i_start = 1'b0;
      @(negedge i_fire);
      chk("len0_state", 96'({o_busy, o_done, o_write_en}), 96'(3'b110));
      @(posedge i_fire); #1;
      @(negedge i_fire);
      chk("len0_idle", 96'({o_busy, o_done}), 96'(0));
      chk("len0_no_write", 96'(wr_cnt - wr0), 96'(0));
      chk("len0_done_once", 96'(done_cnt - dn0), 96'(1));

      // Extra words after length reached and a restart attempt during FILL.
      run_fill(8'h20, 3, 100, 0, 0, 1, 1, 0);

      // Reset mid-fill with buffered words: nothing more written, no done.
      @(posedge i_fire); #1;
      i_start = 1'b1; i_baseAddr = 8'h40; i_len = 9'd8;
      @(posedge i_fire); #1;
      i_start = 1'b0;
      idx = 0;
      repeat (4) begin
         i_valid = 1'b1; i_readReq = 1'b1;
         i_data = {8'h55, DATA_W'(idx)} [DATA_W-1:0];
         @(negedge i_fire);
         if (o_ready) begin
            sb.push_back('{addr: 8'h40 + ADDR_W'(idx), data: i_data});
            idx++;
         end
         @(posedge i_fire); #1;
      end
      chk("buffered_before_reset", 96'(idx), 96'(4));
      rst = 1'b0; i_valid = 1'b0; i_readReq = 1'b0;
      dn0 = done_cnt;
      @(posedge i_fire); #1;
      rst = 1'b1;
      sb.delete();
      wr0 = wr_cnt;
      repeat (3) begin
         @(negedge i_fire);
         chk("post_reset_quiet", 96'({o_write_en, o_busy, o_done, o_ready}), 96'(0));
         @(posedge i_fire); #1;
      end
      chk("reset_no_writes", 96'(wr_cnt - wr0), 96'(0));
      chk("reset_no_done", 96'(done_cnt - dn0), 96'(0));
      run_fill(8'h80, 4, 100, 0, 0, 0, 0, 0);

      // Full-array fill with random stream gaps and read requests.
      snap = wcount;
      b = 8'($urandom_range(255));
      run_fill(b, 256, 70, 30, 0, 0, 0, 0);
      bad = 0;
      for (int a = 0; a < 256; a++) if (wcount[a] - snap[a] != 1) bad++;
      chk("each_addr_once", 96'(bad), 96'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
